// File: rtl/cycle_sequencer_if.sv
// Control/status bundle between the instruction sequencer and its pipeline/memory side.
// master drives run/halt/resume/mem_ready; slave (the sequencer) returns phase enables and status.
interface cycle_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             run;
    logic             halt_req;
    logic             resume;
    logic             mem_ready;
    logic             ph_fetch;
    logic             ph_decode;
    logic             ph_exec;
    logic             ph_mem;
    logic             ph_wb;
    logic             pc_inc;
    logic             busy;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output run, halt_req, resume, mem_ready,
        input  ph_fetch, ph_decode, ph_exec, ph_mem, ph_wb,
        input  pc_inc, busy, halted, timeout, instr_cnt
    );

    modport slave (
        input  run, halt_req, resume, mem_ready,
        output ph_fetch, ph_decode, ph_exec, ph_mem, ph_wb,
        output pc_inc, busy, halted, timeout, instr_cnt
    );
endinterface

// File: rtl/cycle_sequencer.sv
// Five-phase instruction sequencer (F/D/E/M/W) with memory wait states, halt/resume and wait timeout.
// Phase enables are Moore decodes of state; memory backpressure holds FETCH/MEM until mem_ready.
module cycle_sequencer #(
    parameter int CNT_W    = 8,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk_in,
    input  logic             rst,
    cycle_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    logic [2:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             halt_pend_q, halt_pend_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_wait;
    logic             wait_expired;

    always_comb begin
        mem_wait     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !bus.mem_ready;
        wait_expired = mem_wait && (wait_q == WAIT_LIM);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.halt_req)   state_d = S_HALT;
                else if (bus.run)   state_d = S_FETCH;
            end
            S_FETCH: begin
                if (wait_expired)       state_d = S_HALT;
                else if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_MEM;
            S_MEM: begin
                if (wait_expired)       state_d = S_HALT;
                else if (bus.mem_ready) state_d = S_WB;
            end
            S_WB: begin
                if (halt_pend_q || bus.halt_req) state_d = S_HALT;
                else if (bus.run)                state_d = S_FETCH;
                else                             state_d = S_IDLE;
            end
            S_HALT: begin
                if (bus.resume) state_d = bus.run ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // Any state change restarts the wait count, so it is zero on every FETCH/MEM entry.
        wait_d = wait_q;
        if (state_d != state_q) wait_d = '0;
        else if (mem_wait)      wait_d = wait_q + 8'd1;

        halt_pend_d = halt_pend_q;
        if ((state_d == S_HALT) && (state_q != S_HALT))
            halt_pend_d = 1'b0;
        else if (bus.halt_req && (state_q != S_IDLE) && (state_q != S_HALT))
            halt_pend_d = 1'b1;

        timeout_d = timeout_q;
        if (wait_expired)                            timeout_d = 1'b1;
        else if ((state_q == S_HALT) && bus.resume)  timeout_d = 1'b0;

        cnt_d = cnt_q;
        if (state_q == S_WB) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            halt_pend_q <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halt_pend_q <= halt_pend_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ph_fetch  = (state_q == S_FETCH);
    assign bus.ph_decode = (state_q == S_DECODE);
    assign bus.ph_exec   = (state_q == S_EXEC);
    assign bus.ph_mem    = (state_q == S_MEM);
    assign bus.ph_wb     = (state_q == S_WB);
    assign bus.pc_inc    = (state_q == S_FETCH) && bus.mem_ready;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.timeout   = timeout_q;
    assign bus.instr_cnt = cnt_q;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_cycle_sequencer;
    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [4:0] P0 = 5'b00000;
    localparam logic [4:0] PF = 5'b10000;
    localparam logic [4:0] PD = 5'b01000;
    localparam logic [4:0] PE = 5'b00100;
    localparam logic [4:0] PM = 5'b00010;
    localparam logic [4:0] PW = 5'b00001;

    cycle_sequencer_if #(.CNT_W(8)) bus  ();
    cycle_sequencer_if #(.CNT_W(3)) bus3 ();

    cycle_sequencer #(.CNT_W(8), .WAIT_MAX(15)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus.slave)
    );

    // Narrow-counter copy shares all stimulus; only its instr_cnt is examined.
    cycle_sequencer #(.CNT_W(3), .WAIT_MAX(15)) dut3 (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus3.slave)
    );

    assign bus3.run       = bus.run;
    assign bus3.halt_req  = bus.halt_req;
    assign bus3.resume    = bus.resume;
    assign bus3.mem_ready = bus.mem_ready;

    always #5 clk_in = ~clk_in;

    function automatic logic [4:0] ph();
        return {bus.ph_fetch, bus.ph_decode, bus.ph_exec, bus.ph_mem, bus.ph_wb};
    endfunction

    function automatic logic [4:0] exp_ph(input int k);
        case (k % 5)
            0:       return PF;
            1:       return PD;
            2:       return PE;
            3:       return PM;
            default: return PW;
        endcase
    endfunction

    task automatic drive(input logic r, input logic h, input logic rs, input logic m);
        bus.run       = r;
        bus.halt_req  = h;
        bus.resume    = rs;
        bus.mem_ready = m;
    endtask

    task automatic test_reset();
        @(negedge clk_in); drive(1, 1, 1, 1); #1;
        n_checks++; if (ph() !== P0) begin n_fail++; $display("FAIL rst_ph: got %b want %b", ph(), P0); end
        n_checks++; if ({bus.pc_inc, bus.busy, bus.halted, bus.timeout} !== 4'b0000) begin
            n_fail++; $display("FAIL rst_status: pc_inc/busy/halted/timeout=%b want 0000",
                               {bus.pc_inc, bus.busy, bus.halted, bus.timeout}); end
        n_checks++; if (bus.instr_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", bus.instr_cnt); end
        @(negedge clk_in); rst = 1'b0; drive(0, 0, 0, 0); #1;
        n_checks++; if ({ph(), bus.busy} !== 6'b0) begin n_fail++; $display("FAIL rst_release_idle: ph/busy=%b want 0", {ph(), bus.busy}); end
    endtask

    task automatic test_zero_wait();
        @(negedge clk_in); drive(1, 0, 0, 1); #1;
        n_checks++; if (ph() !== P0) begin n_fail++; $display("FAIL zw_idle: got %b want %b", ph(), P0); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in); #1;
            n_checks++; if (ph() !== exp_ph(i)) begin n_fail++; $display("FAIL zw_ph[%0d]: got %b want %b", i, ph(), exp_ph(i)); end
            n_checks++; if (bus.pc_inc !== ((i % 5) == 0)) begin n_fail++; $display("FAIL zw_pc_inc[%0d]: got %b want %b", i, bus.pc_inc, ((i % 5) == 0)); end
        end
        // run drops during the fifth fetch: that instruction must still complete.
        @(negedge clk_in); bus.run = 1'b0; #1;
        n_checks++; if (bus.instr_cnt !== 8'd4) begin n_fail++; $display("FAIL zw_cnt20: got %0d want 4", bus.instr_cnt); end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk_in); #1;
            n_checks++; if (ph() !== exp_ph(i)) begin n_fail++; $display("FAIL zw_drain[%0d]: got %b want %b", i, ph(), exp_ph(i)); end
        end
        @(negedge clk_in); #1;
        n_checks++; if ({ph(), bus.busy} !== 6'b0) begin n_fail++; $display("FAIL zw_idle_end: ph/busy=%b want 0", {ph(), bus.busy}); end
        n_checks++; if (bus.instr_cnt !== 8'd5) begin n_fail++; $display("FAIL zw_cnt_end: got %0d want 5", bus.instr_cnt); end
    endtask

    task automatic test_wait_states();
        @(negedge clk_in); drive(1, 0, 0, 0); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in); bus.mem_ready = (i == 3); if (i == 3) bus.run = 1'b0; #1;
            n_checks++; if (ph() !== PF) begin n_fail++; $display("FAIL ws_ph[%0d]: got %b want %b", i, ph(), PF); end
            n_checks++; if (bus.pc_inc !== (i == 3)) begin n_fail++; $display("FAIL ws_pc_inc[%0d]: got %b want %b", i, bus.pc_inc, (i == 3)); end
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk_in); #1;
            n_checks++; if ({ph(), bus.pc_inc} !== {exp_ph(i), 1'b0}) begin
                n_fail++; $display("FAIL ws_rest[%0d]: ph/pc_inc=%b want %b", i, {ph(), bus.pc_inc}, {exp_ph(i), 1'b0}); end
        end
        @(negedge clk_in); #1;
        n_checks++; if (bus.instr_cnt !== 8'd6) begin n_fail++; $display("FAIL ws_cnt: got %0d want 6", bus.instr_cnt); end
    endtask

    task automatic test_halt_resume();
        @(negedge clk_in); drive(1, 0, 0, 1); #1;
        @(negedge clk_in); #1;
        n_checks++; if (ph() !== PF) begin n_fail++; $display("FAIL hr_fetch: got %b want %b", ph(), PF); end
        @(negedge clk_in); bus.resume = 1'b1; #1;
        @(negedge clk_in); bus.resume = 1'b0; bus.halt_req = 1'b1; #1;
        n_checks++; if (ph() !== PE) begin n_fail++; $display("FAIL hr_exec: got %b want %b (stray resume)", ph(), PE); end
        @(negedge clk_in); bus.halt_req = 1'b0; #1;
        n_checks++; if (ph() !== PM) begin n_fail++; $display("FAIL hr_mem: got %b want %b", ph(), PM); end
        @(negedge clk_in); #1;
        n_checks++; if (ph() !== PW) begin n_fail++; $display("FAIL hr_wb: got %b want %b", ph(), PW); end
        @(negedge clk_in); #1;
        n_checks++; if ({bus.halted, bus.busy, ph()} !== 7'b1000000) begin
            n_fail++; $display("FAIL hr_halted: halted/busy/ph=%b want 1000000", {bus.halted, bus.busy, ph()}); end
        n_checks++; if (bus.instr_cnt !== 8'd7) begin n_fail++; $display("FAIL hr_cnt: got %0d want 7", bus.instr_cnt); end
        @(negedge clk_in); bus.halt_req = 1'b1; #1;
        @(negedge clk_in); bus.halt_req = 1'b0; bus.resume = 1'b1; #1;
        n_checks++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL hr_hold: halted=%b want 1", bus.halted); end
        @(negedge clk_in); bus.resume = 1'b0; bus.run = 1'b0; #1;
        n_checks++; if ({ph(), bus.halted, bus.pc_inc} !== {PF, 2'b01}) begin
            n_fail++; $display("FAIL hr_resume: ph/halted/pc_inc=%b want %b", {ph(), bus.halted, bus.pc_inc}, {PF, 2'b01}); end
        repeat (5) @(negedge clk_in);
        #1;
        n_checks++; if ({ph(), bus.instr_cnt} !== {P0, 8'd8}) begin
            n_fail++; $display("FAIL hr_done: ph=%b cnt=%0d want %b cnt 8", ph(), bus.instr_cnt, P0); end
    endtask

    task automatic test_idle_halt();
        @(negedge clk_in); drive(1, 1, 0, 1); #1;
        @(negedge clk_in); drive(0, 0, 0, 1); #1;
        n_checks++; if ({bus.halted, ph()} !== {1'b1, P0}) begin
            n_fail++; $display("FAIL ih_halt: halted/ph=%b want %b", {bus.halted, ph()}, {1'b1, P0}); end
        @(negedge clk_in); bus.resume = 1'b1; #1;
        @(negedge clk_in); bus.resume = 1'b0; #1;
        n_checks++; if ({bus.halted, bus.busy, ph()} !== 7'b0) begin
            n_fail++; $display("FAIL ih_idle: halted/busy/ph=%b want 0", {bus.halted, bus.busy, ph()}); end
    endtask

    task automatic test_timeout();
        @(negedge clk_in); drive(1, 0, 0, 1); #1;
        @(negedge clk_in); #1;
        @(negedge clk_in); #1;
        @(negedge clk_in); bus.run = 1'b0; #1;
        n_checks++; if (ph() !== PE) begin n_fail++; $display("FAIL to_exec: got %b want %b", ph(), PE); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in); bus.mem_ready = 1'b0; #1;
            n_checks++; if ({ph(), bus.timeout} !== {PM, 1'b0}) begin
                n_fail++; $display("FAIL to_wait[%0d]: ph/timeout=%b want %b", i, {ph(), bus.timeout}, {PM, 1'b0}); end
        end
        @(negedge clk_in); #1;
        n_checks++; if ({bus.halted, bus.timeout, ph()} !== {2'b11, P0}) begin
            n_fail++; $display("FAIL to_halt: halted/timeout/ph=%b want %b", {bus.halted, bus.timeout, ph()}, {2'b11, P0}); end
        n_checks++; if (bus.instr_cnt !== 8'd8) begin n_fail++; $display("FAIL to_cnt: got %0d want 8", bus.instr_cnt); end
        @(negedge clk_in); bus.mem_ready = 1'b1; #1;
        n_checks++; if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b want 1", bus.timeout); end
        @(negedge clk_in); bus.resume = 1'b1; #1;
        @(negedge clk_in); bus.resume = 1'b0; #1;
        n_checks++; if ({bus.timeout, bus.halted, bus.busy} !== 3'b000) begin
            n_fail++; $display("FAIL to_clear: timeout/halted/busy=%b want 000", {bus.timeout, bus.halted, bus.busy}); end
    endtask

    task automatic test_wrap();
        @(negedge clk_in); rst = 1'b1; drive(0, 0, 0, 1);
        @(negedge clk_in); rst = 1'b0;
        @(negedge clk_in); bus.run = 1'b1; #1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk_in); if (i == 40) bus.run = 1'b0; #1;
            n_checks++; if (ph() !== exp_ph(i)) begin n_fail++; $display("FAIL wr_ph[%0d]: got %b want %b", i, ph(), exp_ph(i)); end
            if (i == 40) begin
                n_checks++; if (bus3.instr_cnt !== 3'd0) begin n_fail++; $display("FAIL wr_cnt8: got %0d want 0", bus3.instr_cnt); end
            end
        end
        @(negedge clk_in); #1;
        n_checks++; if (bus.instr_cnt !== 8'd9) begin n_fail++; $display("FAIL wr_cnt_wide: got %0d want 9", bus.instr_cnt); end
        n_checks++; if (bus3.instr_cnt !== 3'd1) begin n_fail++; $display("FAIL wr_cnt_wrap: got %0d want 1", bus3.instr_cnt); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_in); drive(1, 0, 0, 1); #1;
        repeat (3) @(negedge clk_in);
        bus.run = 1'b0;
        @(negedge clk_in); bus.mem_ready = 1'b0; #1;
        n_checks++; if (ph() !== PM) begin n_fail++; $display("FAIL rm_mem: got %b want %b", ph(), PM); end
        #2; rst = 1'b1; bus.mem_ready = 1'b1; #1;
        n_checks++; if ({ph(), bus.pc_inc, bus.busy, bus.halted} !== 8'b0) begin
            n_fail++; $display("FAIL rm_async: ph/pc_inc/busy/halted=%b want 0", {ph(), bus.pc_inc, bus.busy, bus.halted}); end
        n_checks++; if (bus.instr_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", bus.instr_cnt); end
        @(negedge clk_in); rst = 1'b0; bus.run = 1'b1; #1;
        n_checks++; if ({ph(), bus.instr_cnt} !== {P0, 8'd0}) begin
            n_fail++; $display("FAIL rm_idle: ph=%b cnt=%0d want %b cnt 0", ph(), bus.instr_cnt, P0); end
        @(negedge clk_in); bus.run = 1'b0; #1;
        n_checks++; if (ph() !== PF) begin n_fail++; $display("FAIL rm_restart: got %b want %b", ph(), PF); end
        repeat (5) @(negedge clk_in);
        #1;
        n_checks++; if (bus.instr_cnt !== 8'd1) begin n_fail++; $display("FAIL rm_after: got %0d want 1", bus.instr_cnt); end
    endtask

    initial begin
        drive(0, 0, 0, 0);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_halt_resume();
        test_idle_halt();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
